// File: rtl/umi_resp_router.sv
// Response router for the UMI arbiter: an in-order FIFO of winning requester indices steers
// returning responses back to the right port. `define UMI_RESP_ROUTER_ERR_EN to build the sticky error detectors.
module umi_resp_router #(
  parameter int    N      = 4,
  parameter int    DEPTH  = 8,
  parameter int    DW     = 256,
  parameter string TARGET = "DEFAULT"
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic [N-1:0]  req_grants,
  input  logic          req_accept,
  output logic          order_full,
  input  logic          resp_valid_in,
  input  logic          resp_last_in,
  input  logic [DW-1:0] resp_packet_in,
  output logic          resp_ready_in,
  output logic [N-1:0]  resp_valid_out,
  output logic [DW-1:0] resp_packet_out,
  input  logic [N-1:0]  resp_ready_out,
  output logic          err_onehot,
  output logic          err_underflow
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  function automatic logic [IW-1:0] lowest_idx(input logic [N-1:0] vec);
    logic [IW-1:0] idx;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) idx = IW'(i);
      else        idx = idx;
    end
    return idx;
  endfunction

  logic [IW-1:0] fifo_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [CW-1:0] count_next_s;
  logic          full_r;
  logic          empty_s;
  logic          push_s;
  logic          pop_s;
  logic [IW-1:0] head_s;

  assign empty_s         = (count_r == CW'(0));
  assign head_s          = fifo_r[rd_ptr_r];
  assign push_s          = req_accept & (|req_grants) & ~full_r;
  assign resp_ready_in   = ~empty_s & resp_ready_out[head_s];
  assign pop_s           = resp_valid_in & resp_ready_in & resp_last_in;
  assign resp_packet_out = resp_packet_in;
  assign order_full      = full_r;

  // Route the beat valid to the requester at the head of the order FIFO.
  always_comb begin
    resp_valid_out = '0;
    if (resp_valid_in && !empty_s) resp_valid_out[head_s] = 1'b1;
    else                           resp_valid_out = '0;
  end

  // Occupancy after this cycle's push/pop.
  always_comb begin
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CW'(1);
      2'b01:   count_next_s = count_r - CW'(1);
      default: count_next_s = count_r;
    endcase
  end

  // Pointers, occupancy and the registered full flag.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      full_r   <= 1'b0;
    end else begin
      wr_ptr_r <= wr_ptr_r + AW'(push_s);
      rd_ptr_r <= rd_ptr_r + AW'(pop_s);
      count_r  <= count_next_s;
      full_r   <= (count_next_s == CW'(DEPTH));
    end
  end

  // FPGA builds leave the index storage unreset so it can map to distributed RAM.
  if (TARGET == "FPGA") begin : g_store_nores
    // Index storage write.
    always_ff @(posedge clk) begin
      if (push_s) fifo_r[wr_ptr_r] <= lowest_idx(req_grants);
    end
  end else begin : g_store_rst
    // Index storage write with reset.
    always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
        for (int i = 0; i < DEPTH; i++) fifo_r[i] <= '0;
      end else if (push_s) begin
        fifo_r[wr_ptr_r] <= lowest_idx(req_grants);
      end
    end
  end

`ifdef UMI_RESP_ROUTER_ERR_EN
  function automatic logic is_onehot(input logic [N-1:0] vec);
    return (vec != '0) && ((vec & (vec - N'(1))) == '0);
  endfunction

  logic err_onehot_r;
  logic err_underflow_r;

  // Sticky protocol error flags, cleared only by reset.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      err_onehot_r    <= 1'b0;
      err_underflow_r <= 1'b0;
    end else begin
      err_onehot_r    <= err_onehot_r | (push_s & ~is_onehot(req_grants));
      err_underflow_r <= err_underflow_r | (resp_valid_in & empty_s);
    end
  end

  assign err_onehot    = err_onehot_r;
  assign err_underflow = err_underflow_r;
`else
  assign err_onehot    = 1'b0;
  assign err_underflow = 1'b0;
`endif

endmodule

// File: doc/umi_resp_router.md
# umi_resp_router

Response-side companion to the UMI arbiter: records which requester won each accepted request, then steers returning responses back to that requester in the same order. Sits between the shared downstream response channel and the N per-requester response ports. It holds an in-order grant FIFO and routes with zero added latency on the data path.

## Interface
- N, 4, number of requesters (N ≥ 1)
- DEPTH, 8, outstanding-request capacity (power of 2, ≥ 2)
- DW, 256, response packet width
- TARGET, "DEFAULT", implementation target (SIM, ASIC, FPGA, ...)

- clk  input  1  clock
- nreset  input  1  reset, asynchronous, active-low
- req_grants  input  N  one-hot grant vector from the arbiter
- req_accept  input  1  granted request transferred downstream this cycle
- order_full  output  1  FIFO full; arbiter must mask all requests
- resp_valid_in  input  1  downstream response beat valid
- resp_last_in  input  1  final beat of current response
- resp_packet_in  input  DW  response beat
- resp_ready_in  output  1  router can accept the beat
- resp_valid_out  output  N  per-requester valid, at most one set
- resp_packet_out  output  DW  resp_packet_in, broadcast to all requesters
- resp_ready_out  input  N  per-requester ready
- err_onehot  output  1  sticky: push with non-one-hot req_grants
- err_underflow  output  1  sticky: resp_valid_in while FIFO empty

## Operation
- Index width IW = max(1, clog2(N)). FIFO stores the IW-bit index; count is 0..DEPTH (clog2(DEPTH)+1 bits). Pointers wrap modulo DEPTH.
- Push when req_accept & |req_grants & ~order_full. The stored index is the lowest set bit of req_grants. A push while full is dropped; the arbiter contract forbids it.
- Head index is h. empty = (count==0).
- resp_valid_out[h] = resp_valid_in & ~empty. All other bits are 0.
- resp_ready_in = ~empty & resp_ready_out[h].
- Beat transfer: resp_valid_in & resp_ready_in. Pop on a transfer with resp_last_in=1.
- A multi-beat response stays on one head entry until its last beat.
- Push and pop in the same cycle leave count unchanged and advance both pointers.
- order_full = (count==DEPTH), taken from registers.
- While empty, incoming responses stall (resp_ready_in=0) and are not dropped.

## Timing
- Reset values: count=0, pointers=0, order_full=0, resp_ready_in=0, resp_valid_out=0, both error flags 0.
- The data path is combinational. resp_packet_in to resp_packet_out has 0 cycles of latency. resp_ready_out to resp_ready_in is a combinational path.
- A pushed entry becomes the head no earlier than the next cycle. A response cannot be routed in its own push cycle.
- order_full asserts in the cycle after the DEPTH-th outstanding push. It deasserts in the cycle after a pop.
- Asserting reset mid-operation clears the FIFO. In-flight responses are discarded from tracking, and the outputs return to reset values asynchronously.

## Configuration
- UMI_RESP_ROUTER_ERR_EN, when defined, compiles in the err_onehot and err_underflow detectors.
  - Each flag sets on its condition.
  - Each flag clears only on reset.
- When UMI_RESP_ROUTER_ERR_EN is undefined, both error ports are tied to 0 and no detection logic exists.
- Routing behaviour is identical in both builds.

## Test plan
- Ordering, N=4:
  - Stimulus: accept grants 0100, 0001, 1000 on consecutive cycles, then three single-beat responses A, B, C.
  - Required: A on port 2, B on port 0, C on port 3. Count returns to 0.
- Multi-beat response:
  - Stimulus: grant 0010, then a 4-beat response with last on beat 4.
  - Required: resp_valid_out=0010 for all 4 beats; pop only after beat 4. A second queued entry is not exposed until then.
- Backpressure:
  - Stimulus: head index 1 with resp_ready_out=1101.
  - Required: resp_ready_in=0 and no pop.
  - Stimulus: raise bit 1.
  - Required: transfer that same cycle.
- Full, DEPTH=8:
  - Stimulus: 8 accepts with no responses.
  - Required: order_full=1; a 9th accept is ignored (count stays 8).
  - Stimulus: one response completes.
  - Required: order_full=0 on the next cycle.
- Simultaneous push/pop and wrap:
  - Stimulus: at count=3, push and pop in the same cycle.
  - Required: count stays 3.
  - Stimulus: run 20 mixed transactions.
  - Required: pointer wrap preserves order.
- Errors and reset:
  - Stimulus: with UMI_RESP_ROUTER_ERR_EN defined, req_grants=0110 with accept, then a response while empty.
  - Required: both flags set and stay set.
  - Stimulus: assert nreset mid-stream.
  - Required: all outputs at reset values immediately.
